seq_matcher: RTL and testbench

- Parametrised streaming pattern recognizer over a symbol stream; generalises the fixed-pattern regex FSM.
- Pattern is runtime-programmable: length up to MAX_LEN, symbol width SYM_W, per-position wildcard.
- Two modes:
  - EXACT: the whole message must equal the pattern.
  - CONTAINS: the pattern may occur anywhere; overlapping hits are counted.
- Sits between the symbol source and the control/status logic; reports once per message, with done/result.

---
 rtl/seq_matcher.sv | 151 +++++++++++++++
 tb/tb_seq_matcher.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_matcher.sv
// Streaming pattern recognizer: runtime-programmable pattern with per-position wildcards,
// EXACT (whole message) or CONTAINS (overlapping hit count) verdict once per message.
module seq_matcher #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0] cfg_idx,
  input  logic [SYM_W-1:0]           cfg_sym,
  input  logic                       cfg_wild,
  input  logic [$clog2(MAX_LEN):0]   cfg_len,
  input  logic                       mode,
  input  logic                       sym_valid,
  input  logic [SYM_W-1:0]           sym_in,
  input  logic                       last_symbol,
  output logic                       busy,
  output logic                       done,
  output logic                       result,
  output logic [CNT_W-1:0]           hit_count
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;
  // One spare bit so the position counter can sit at MAX_LEN+1.
  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);
  localparam logic [CW-1:0] POS_MAX = CW'(MAX_LEN + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state_reg, state_next;

  logic [SYM_W-1:0] pat_reg [MAX_LEN];
  logic [MAX_LEN-1:0] wild_reg;
  logic [CW-1:0] len_reg;
  logic [SYM_W-1:0] win_reg [MAX_LEN-1];
  logic [CW-1:0] pos_reg, fill_reg;
  logic mis_reg, mode_reg;
  logic [CNT_W-1:0] hits_reg, hit_count_reg;
  logic done_reg, result_reg;

  logic first, cfg_ok, mode_eff;
  logic [CW-1:0] cfg_len_ext, cfg_len_clamped;
  logic [CW-1:0] pos_base, fill_base, pos_next, fill_next;
  logic [CNT_W-1:0] hits_base, hits_next, exact_cnt;
  logic mis_base, mis_next, exact_sym_ok, exact_ok, hit;
  logic [IDX_W-1:0] eidx;
  logic [SYM_W-1:0] win_next [MAX_LEN];
  logic [MAX_LEN-1:0] pos_ok;

  assign first       = sym_valid & (state_reg == IDLE);
  assign cfg_ok      = cfg_we & (state_reg == IDLE) & ~sym_valid;
  assign cfg_len_ext = CW'(cfg_len);
  assign cfg_len_clamped = (cfg_len_ext > LEN_MAX) ? LEN_MAX : cfg_len_ext;

  // Window: index 0 is the incoming symbol, index k the symbol k places earlier.
  assign win_next[0] = sym_in;
  generate
    for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_shift
      assign win_next[gi] = first ? '0 : win_reg[gi-1];
    end
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      logic [IDX_W-1:0] pidx;
      assign pidx = IDX_W'(len_reg - CW'(gi + 1));
      assign pos_ok[gi] = (CW'(gi) >= len_reg) | wild_reg[pidx] | (pat_reg[pidx] == win_next[gi]);
    end
  endgenerate

  always_comb begin
    mode_eff  = first ? mode : mode_reg;
    pos_base  = first ? '0 : pos_reg;
    fill_base = first ? '0 : fill_reg;
    mis_base  = first ? 1'b0 : mis_reg;
    hits_base = first ? '0 : hits_reg;

    pos_next  = (pos_base == POS_MAX) ? POS_MAX : pos_base + CW'(1);
    fill_next = (fill_base == LEN_MAX) ? LEN_MAX : fill_base + CW'(1);

    eidx         = IDX_W'(pos_next - CW'(1));
    exact_sym_ok = wild_reg[eidx] | (pat_reg[eidx] == sym_in);
    mis_next     = mis_base | (pos_next > len_reg) | ~exact_sym_ok;
    exact_ok     = ~mis_next & (pos_next == len_reg) & (len_reg != '0);
    exact_cnt    = CNT_W'(exact_ok);

    hit       = (fill_next >= len_reg) & (len_reg != '0) & (&pos_ok);
    hits_next = (hit && hits_base != '1) ? hits_base + CNT_W'(1) : hits_base;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sym_valid & ~last_symbol) state_next = ACTIVE;
      ACTIVE:  if (sym_valid & last_symbol)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ACTIVE);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < MAX_LEN; i++) pat_reg[i] <= '0;
      for (int i = 0; i < MAX_LEN - 1; i++) win_reg[i] <= '0;
      wild_reg      <= '0;
      len_reg       <= '0;
      pos_reg       <= '0;
      fill_reg      <= '0;
      mis_reg       <= 1'b0;
      mode_reg      <= 1'b0;
      hits_reg      <= '0;
      hit_count_reg <= '0;
      done_reg      <= 1'b0;
      result_reg    <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      result_reg <= 1'b0;
      if (cfg_ok) begin
        pat_reg[cfg_idx]  <= cfg_sym;
        wild_reg[cfg_idx] <= cfg_wild;
        len_reg           <= cfg_len_clamped;
      end
      if (sym_valid) begin
        mode_reg <= mode_eff;
        pos_reg  <= pos_next;
        fill_reg <= fill_next;
        mis_reg  <= mis_next;
        hits_reg <= hits_next;
        for (int i = 0; i < MAX_LEN - 1; i++) win_reg[i] <= win_next[i];
        if (last_symbol) begin
          done_reg      <= 1'b1;
          result_reg    <= mode_eff ? (hits_next != '0) : exact_ok;
          hit_count_reg <= mode_eff ? hits_next : exact_cnt;
        end
      end
    end
  end

  assign done      = done_reg;
  assign result    = result_reg;
  assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_seq_matcher.sv
// Randomized scoreboard bench for seq_matcher against a message-level reference model.
module tb_seq_matcher;
  localparam int SYM_W = 2;
  localparam int MAX_LEN = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [SYM_W-1:0] cfg_sym = '0;
  logic cfg_wild = 1'b0;
  logic [3:0] cfg_len = '0;
  logic mode = 1'b0;
  logic sym_valid = 1'b0;
  logic [SYM_W-1:0] sym_in = '0;
  logic last_symbol = 1'b0;
  logic busy, done, result;
  logic [CNT_W-1:0] hit_count;

  always #5 clk = ~clk;

  seq_matcher #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .cfg_wild(cfg_wild), .cfg_len(cfg_len), .mode(mode), .sym_valid(sym_valid),
    .sym_in(sym_in), .last_symbol(last_symbol), .busy(busy), .done(done),
    .result(result), .hit_count(hit_count)
  );

  typedef struct { bit r; int h; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  // Reference model state: pattern as programmed, message as sent.
  bit [SYM_W-1:0] m_pat [MAX_LEN];
  bit m_wild [MAX_LEN];
  int m_len = 0;
  bit [SYM_W-1:0] msg[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_eval(input bit md, output bit r, output int h);
    int n = msg.size();
    bit ok;
    h = 0;
    if (!md) begin
      ok = (m_len != 0) && (n == m_len);
      for (int i = 0; i < n && ok; i++)
        if (!(m_wild[i] || m_pat[i] == msg[i])) ok = 0;
      r = ok;
      h = int'(ok);
    end else begin
      if (m_len != 0)
        for (int s = 0; s + m_len <= n; s++) begin
          ok = 1;
          for (int j = 0; j < m_len; j++)
            if (!(m_wild[j] || m_pat[j] == msg[s + j])) ok = 0;
          if (ok && h < 255) h++;
        end
      r = (h > 0);
    end
  endfunction

  // Monitor: pops an expectation whenever the DUT signals done.
  always @(negedge clk) begin
    if (!res) begin
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          mon_e = sb.pop_front();
          $display("msg verdict: result=%0d hit_count=%0d (expect %0d/%0d)", result, hit_count, mon_e.r, mon_e.h);
          check("done_latency", cyc, mon_e.due);
          check("result", int'(result), int'(mon_e.r));
          check("hit_count", int'(hit_count), mon_e.h);
        end
      end else begin
        check("result_without_done", int'(result), 0);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          void'(sb.pop_front());
          check("missing_done", 0, 1);
        end
      end
    end
  end

  task automatic drive_cfg_junk(input bit junk);
    cfg_we   = junk;
    cfg_idx  = 3'($urandom);
    cfg_sym  = 2'($urandom);
    cfg_wild = 1'($urandom);
    cfg_len  = 4'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sym_valid = 0; last_symbol = 0; cfg_we = 0;
    end
  endtask

  task automatic cfg_write(input int idx, input int s, input bit w, input int len);
    @(negedge clk);
    sym_valid = 0; last_symbol = 0;
    cfg_we = 1; cfg_idx = 3'(idx); cfg_sym = 2'(s); cfg_wild = w; cfg_len = 4'(len);
    m_pat[idx] = 2'(s);
    m_wild[idx] = w;
    m_len = (len > MAX_LEN) ? MAX_LEN : len;
  endtask

  // Sends the queued message; random gaps and (optionally) guarded config writes inside it.
  task automatic send(input bit md, input int gap_pct, input bit junk);
    exp_t e;
    int g;
    for (int i = 0; i < msg.size(); i++) begin
      g = (i > 0 && $urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        check("busy_gap", int'(busy), 1);
        sym_valid = 0; last_symbol = 1'($urandom); sym_in = 2'($urandom); mode = 1'($urandom);
        drive_cfg_junk(junk);
      end
      @(negedge clk);
      check("busy", int'(busy), int'(i > 0));
      sym_valid = 1;
      sym_in = msg[i];
      last_symbol = (i == msg.size() - 1);
      mode = (i == 0) ? md : 1'($urandom);
      drive_cfg_junk(junk);
      if (i == msg.size() - 1) begin
        model_eval(md, e.r, e.h);
        e.due = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MAX_LEN; i++) begin m_pat[i] = 0; m_wild[i] = 0; end
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_hit_count", int'(hit_count), 0);
    res = 0;
    idle(1);

    // EXACT {1,2,3}
    cfg_write(0, 1, 0, 3); cfg_write(1, 2, 0, 3); cfg_write(2, 3, 0, 3);
    msg = {2'd1, 2'd2, 2'd3}; send(0, 0, 0);
    msg = {2'd1, 2'd2, 2'd3, 2'd3}; send(0, 0, 0);
    // Guarded writes: pattern must stay {1,2,3}
    msg = {2'd1, 2'd2, 2'd3}; send(0, 50, 1);
    msg = {2'd1, 2'd2, 2'd3}; send(0, 80, 1);
    idle(2);

    // Wildcard {0,*}
    cfg_write(0, 0, 0, 2); cfg_write(1, 1, 1, 2);
    msg = {2'd0, 2'd3}; send(0, 0, 0);
    msg = {2'd0, 2'd0}; send(0, 30, 0);
    msg = {2'd1, 2'd3}; send(0, 0, 0);
    idle(1);

    // CONTAINS {0,0}, overlapping hits, back-to-back and gapped
    cfg_write(0, 0, 0, 2); cfg_write(1, 0, 0, 2);
    msg = {2'd1, 2'd0, 2'd0, 2'd0, 2'd2}; send(1, 0, 0);
    msg = {2'd1, 2'd2}; send(1, 0, 0);
    msg = {2'd0, 2'd0, 2'd0}; send(1, 60, 0);
    msg = {2'd0}; send(1, 0, 0);
    idle(1);

    // Length clamp: cfg_len=15 behaves as 8
    for (int i = 0; i < MAX_LEN; i++) cfg_write(i, i % 4, 0, 15);
    msg.delete();
    for (int i = 0; i < MAX_LEN; i++) msg.push_back(2'(i % 4));
    send(0, 0, 0);
    msg.push_back(2'd0); send(0, 0, 0);
    send(1, 20, 0);
    idle(1);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      int n;
      if ($urandom_range(3) == 0) begin
        idle($urandom_range(0, 1));
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++)
          cfg_write($urandom_range(0, MAX_LEN - 1), $urandom_range(0, 3),
                    $urandom_range(3) == 0,
                    ($urandom_range(4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4));
      end
      msg.delete();
      if ($urandom_range(2) == 0 && m_len > 0) begin
        for (int i = 0; i < m_len; i++) msg.push_back(m_wild[i] ? 2'($urandom) : m_pat[i]);
      end else begin
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++)
          msg.push_back($urandom_range(1) ? 2'($urandom_range(0, 1)) : 2'($urandom));
      end
      send(1'($urandom), $urandom_range(0, 40), $urandom_range(3) == 0);
      if ($urandom_range(1)) idle($urandom_range(1, 2));
    end

    // Reset mid-message after a verdict with nonzero hit_count
    idle(1);
    cfg_write(0, 0, 0, 2); cfg_write(1, 0, 0, 2);
    msg = {2'd0, 2'd0, 2'd0}; send(1, 0, 0);
    idle(2);
    @(negedge clk); sym_valid = 1; sym_in = 2'd0; last_symbol = 0; mode = 1;
    @(negedge clk); sym_in = 2'd0;
    @(negedge clk); sym_valid = 0;
    res = 1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_result", int'(result), 0);
    check("rst_mid_hit_count", int'(hit_count), 0);
    for (int i = 0; i < MAX_LEN; i++) begin m_pat[i] = 0; m_wild[i] = 0; end
    m_len = 0;
    @(negedge clk); res = 0;
    idle(3);
    msg = {2'd0}; send(0, 0, 0);
    msg = {2'd0, 2'd0}; send(1, 0, 0);
    idle(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
